// File: rtl/fetch_decode_if.sv
// Bundle between the fetch/decode stage, the instruction memory port and the
// register-file/ALU block.
//   master : fetch/decode side (drives fetch address/request and decoded fields)
//   slave  : memory + register-file/ALU side (drives ack/data and EQ)
// Signals:
//   imem_addr/imem_req   fetch address and request
//   imem_ack/imem_data   memory handshake and instruction word
//   EQ                   ALU equality flag
//   rs1/rs2/rd           decoded register addresses
//   ALUsrc/ALUctrl       operand select and ALU operation
//   ImmOp                sign-extended immediate
//   RegWrite/exec        write enable and execute-cycle strobe
interface fetch_decode_if #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32
);
    logic [A_WIDTH-1:0] imem_addr;
    logic               imem_req;
    logic               imem_ack;
    logic [D_WIDTH-1:0] imem_data;
    logic               EQ;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               ALUsrc;
    logic               ALUctrl;
    logic [D_WIDTH-1:0] ImmOp;
    logic               RegWrite;
    logic               exec;

    modport master (
        output imem_addr, imem_req,
        input  imem_ack, imem_data, EQ,
        output rs1, rs2, rd, ALUsrc, ALUctrl, ImmOp, RegWrite, exec
    );

    modport slave (
        input  imem_addr, imem_req,
        output imem_ack, imem_data, EQ,
        input  rs1, rs2, rd, ALUsrc, ALUctrl, ImmOp, RegWrite, exec
    );
endinterface

// File: rtl/fetch_decode_block.sv
// Fetch/decode stage of the reduced RISC-V datapath (addi/add/bne).
// Owns the PC, fetches over a req/ack port, holds the instruction in IR and
// decodes it combinationally for the register-file/ALU block. One instruction
// retires per EXEC cycle; bne is resolved with EQ sampled in EXEC.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_decode_if.master (imem_*, EQ, decoded fields, RegWrite, exec)
// Configuration macro:
//   FETCH_TRAP_EN  defined   -> an illegal instruction in EXEC enters HALT
//                              (terminal until reset, PC frozen at the fault)
//                  undefined -> an illegal instruction retires as a NOP
module fetch_decode_block #(
    parameter int unsigned        A_WIDTH  = 32,
    parameter int unsigned        D_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst_n,
    fetch_decode_if.master bus
);
    localparam logic [D_WIDTH-1:0] NOP = D_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
`ifdef FETCH_TRAP_EN
        ,
        S_HALT  = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic [D_WIDTH-1:0] ir_q, ir_d;

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               is_addi, is_add, is_bne, is_legal;
    logic               alusrc, aluctrl;
    logic signed [D_WIDTH-1:0] imm;
    logic [A_WIDTH-1:0] pc_seq, pc_br;

    function automatic logic signed [D_WIDTH-1:0] sext_i(input logic [31:0] ir);
        return {{(D_WIDTH-12){ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic signed [D_WIDTH-1:0] sext_b(input logic [31:0] ir);
        return {{(D_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    assign opc = ir_q[6:0];
    assign f3  = ir_q[14:12];
    assign f7  = ir_q[31:25];

    assign is_addi  = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_add   = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    assign is_bne   = (opc == 7'b1100011) && (f3 == 3'b001);
    assign is_legal = is_addi || is_add || is_bne;

    // Illegal encodings fall through with every enable and the immediate at 0.
    always_comb begin
        alusrc  = 1'b0;
        aluctrl = 1'b0;
        imm     = '0;
        if (is_addi) begin
            alusrc = 1'b1;
            imm    = sext_i(ir_q[31:0]);
        end else if (is_bne) begin
            aluctrl = 1'b1;
            imm     = sext_b(ir_q[31:0]);
        end
    end

    // Both adds wrap modulo 2^A_WIDTH; the size cast sign-extends the offset.
    assign pc_seq = pc_q + A_WIDTH'(4);
    assign pc_br  = pc_q + A_WIDTH'(imm);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef FETCH_TRAP_EN
                if (!is_legal) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = (is_bne && !bus.EQ) ? pc_br : pc_seq;
                end
`else
                state_d = S_FETCH;
                pc_d    = (is_bne && !bus.EQ) ? pc_br : pc_seq;
`endif
            end
`ifdef FETCH_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Control outputs decode straight from state so reset clears them at once.
    assign bus.imem_addr = pc_q;
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.exec      = (state_q == S_EXEC);
    assign bus.RegWrite  = (state_q == S_EXEC) && (is_addi || is_add);
    assign bus.rs1       = ir_q[19:15];
    assign bus.rs2       = ir_q[24:20];
    assign bus.rd        = ir_q[11:7];
    assign bus.ALUsrc    = alusrc;
    assign bus.ALUctrl   = aluctrl;
    assign bus.ImmOp     = imm;
endmodule

// File: tb/tb_fetch_decode_block.sv
module tb_fetch_decode_block;
    logic clk;
    logic rst_n;

    fetch_decode_if #(.A_WIDTH(32), .D_WIDTH(32)) bus ();

    fetch_decode_block #(
        .A_WIDTH (32),
        .D_WIDTH (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        eq;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alusrc;
        logic        aluctrl;
        logic [31:0] imm;
        logic        rw;
        logic [31:0] next_pc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    vec_t tbl [7];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a fetch request, optionally stall, deliver the word,
    // check the EXEC-cycle decode and the address of the following fetch.
    task automatic fetch_exec(input vec_t x, input int waits);
        int n;
        n = 0;
        bus.imem_ack = 1'b0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, x.pc);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_req", 32'(bus.imem_req), 32'd1);
            chk("wait_addr", bus.imem_addr, x.pc);
            chk("wait_exec", 32'(bus.exec), 32'd0);
            chk("wait_rw", 32'(bus.RegWrite), 32'd0);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = x.instr;
        step();
        bus.imem_ack = 1'b0;
        bus.EQ       = x.eq;
        chk("exec", 32'(bus.exec), 32'd1);
        chk("exec_req", 32'(bus.imem_req), 32'd0);
        chk("rs1", 32'(bus.rs1), 32'(x.rs1));
        chk("rs2", 32'(bus.rs2), 32'(x.rs2));
        chk("rd", 32'(bus.rd), 32'(x.rd));
        chk("ALUsrc", 32'(bus.ALUsrc), 32'(x.alusrc));
        chk("ALUctrl", 32'(bus.ALUctrl), 32'(x.aluctrl));
        chk("ImmOp", bus.ImmOp, x.imm);
        chk("RegWrite", 32'(bus.RegWrite), 32'(x.rw));
        step();
        chk("next_exec", 32'(bus.exec), 32'd0);
        chk("next_rw", 32'(bus.RegWrite), 32'd0);
        chk("next_req", 32'(bus.imem_req), 32'd1);
        chk("next_addr", bus.imem_addr, x.next_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        //           pc            instr          eq    rs1    rs2    rd     src   ctl   imm            rw    next
        tbl[0] = '{32'h0000_0000, 32'h0050_0513, 1'b0, 5'd0,  5'd5,  5'd10, 1'b1, 1'b0, 32'h0000_0005, 1'b1, 32'h0000_0004};
        tbl[1] = '{32'h0000_0004, 32'h0020_81B3, 1'b0, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        tbl[2] = '{32'h0000_0008, 32'hFE00_1CE3, 1'b0, 5'd0,  5'd0,  5'd25, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000};
        tbl[3] = '{32'h0000_0000, 32'hFFF0_8093, 1'b0, 5'd1,  5'd31, 5'd1,  1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0004};
        tbl[4] = '{32'h0000_0004, 32'h0070_0013, 1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b0, 32'h0000_0007, 1'b1, 32'h0000_0008};
        tbl[5] = '{32'h0000_0008, 32'hFE00_1CE3, 1'b1, 5'd0,  5'd0,  5'd25, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_000C};
        tbl[6] = '{32'h0000_000C, 32'h0020_81B3, 1'b1, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};

        rst_n         = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
        bus.EQ        = 1'b0;
        #1;
        step();
        step();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_exec", 32'(bus.exec), 32'd0);
        chk("rst_rw", 32'(bus.RegWrite), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_rd", 32'(bus.rd), 32'd0);
        chk("rst_alusrc", 32'(bus.ALUsrc), 32'd1);
        chk("rst_imm", bus.ImmOp, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        step();
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);

        for (int i = 0; i < 7; i++) begin
            fetch_exec(tbl[i], 0);
        end

`ifdef FETCH_TRAP_EN
        chk("trap_addr", bus.imem_addr, 32'h10);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hFFFF_FFFF;
        step();
        bus.imem_ack = 1'b0;
        chk("trap_exec", 32'(bus.exec), 32'd1);
        chk("trap_rw", 32'(bus.RegWrite), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack = 1'b1;
            step();
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_exec", 32'(bus.exec), 32'd0);
            chk("halt_rw", 32'(bus.RegWrite), 32'd0);
            chk("halt_addr", bus.imem_addr, 32'h10);
        end
        bus.imem_ack = 1'b0;
`else
        v = '{32'h10, 32'hFFFF_FFFF, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14};
        fetch_exec(v, 0);
        v = '{32'h14, 32'h4020_81B3, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h18};
        fetch_exec(v, 0);
`endif

        // Mid-run reset; ack during reset and IDLE must not load IR.
        rst_n         = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h0020_81B3;
        #1;
        chk("mrst_req", 32'(bus.imem_req), 32'd0);
        chk("mrst_exec", 32'(bus.exec), 32'd0);
        chk("mrst_rw", 32'(bus.RegWrite), 32'd0);
        chk("mrst_addr", bus.imem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mrel_req", 32'(bus.imem_req), 32'd0);
        chk("mrel_addr", bus.imem_addr, 32'h0);
        step();
        bus.imem_ack = 1'b0;
        chk("mrel_req1", 32'(bus.imem_req), 32'd1);
        chk("idle_ack_rd", 32'(bus.rd), 32'd0);
        chk("idle_ack_src", 32'(bus.ALUsrc), 32'd1);

        // Ack held through EXEC must not reload IR.
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h0050_0513;
        step();
        bus.imem_data = 32'h0020_81B3;
        chk("e_exec", 32'(bus.exec), 32'd1);
        chk("e_rw", 32'(bus.RegWrite), 32'd1);
        step();
        bus.imem_ack = 1'b0;
        chk("e_ign_rd", 32'(bus.rd), 32'd10);
        chk("e_ign_addr", bus.imem_addr, 32'h4);
        chk("e_ign_req", 32'(bus.imem_req), 32'd1);

        // Reset asserted in the middle of an EXEC cycle.
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h0050_0513;
        step();
        bus.imem_ack = 1'b0;
        chk("xr_exec_pre", 32'(bus.exec), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("xr_exec", 32'(bus.exec), 32'd0);
        chk("xr_rw", 32'(bus.RegWrite), 32'd0);
        chk("xr_req", 32'(bus.imem_req), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("xr_addr", bus.imem_addr, 32'h0);
        step();
        chk("xr_req1", 32'(bus.imem_req), 32'd1);

        // Three wait states on a backward bne to FFFF_FFFC, then wrap to 0.
        v = '{32'h0, 32'hFE00_1EE3, 1'b0, 5'd0, 5'd0, 5'd29, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC};
        fetch_exec(v, 3);
        v = '{32'hFFFF_FFFC, 32'h0050_0513, 1'b0, 5'd0, 5'd5, 5'd10, 1'b1, 1'b0, 32'h5, 1'b1, 32'h0};
        fetch_exec(v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
